// File: rtl/ad7266_frame_packer_if.sv
// rtl/ad7266_frame_packer_if.sv - ADC capture and word write-port bundle for the AD7266 frame packer
// slave is the packer side; master is the driving/observing side.
interface ad7266_frame_packer_if;
  logic        enable;
  logic        ad_done;
  logic [11:0] dataa;
  logic [11:0] datab;
  logic [2:0]  a_sel;
  logic        wr_full;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        busy;
  logic [7:0]  ovf_cnt;

  modport slave (
    input  enable, ad_done, dataa, datab, wr_full,
    output a_sel, wr_en, wr_data, busy, ovf_cnt
  );

  modport master (
    output enable, ad_done, dataa, datab, wr_full,
    input  a_sel, wr_en, wr_data, busy, ovf_cnt
  );
endinterface

// File: rtl/ad7266_frame_packer.sv
// rtl/ad7266_frame_packer.sv - AD7266 channel sequencer and sweep framer (header, A/B words, checksum)
// Optional macro CHK_EN adds the per-sweep XOR checksum word after the last channel.
module ad7266_frame_packer #(
  parameter int unsigned NUM_CH   = 8,
  parameter logic [15:0] HDR_WORD = 16'hA55A
) (
  input logic                  SCLK,
  input logic                  rst_n,
  ad7266_frame_packer_if.slave bus
);

  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    WA   = 3'd2,
    WB   = 3'd3
`ifdef CHK_EN
    ,
    CHK  = 3'd4
`endif
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_wr_data;
  logic [15:0] w_wr_data_next;
  logic [2:0]  r_a_sel;
  logic [2:0]  w_a_sel_inc;
  logic [2:0]  r_cap_ch;
  logic [11:0] r_dataa;
  logic [11:0] r_datab;
  logic [7:0]  r_ovf_cnt;
  logic        w_busy;
  logic        w_accept;
  logic        w_drop;
`ifdef CHK_EN
  logic        w_advance;
  logic        r_abort;
  logic [15:0] r_chk;
`endif

  assign w_busy      = (r_state != IDLE);
  assign w_accept    = bus.ad_done && bus.enable && !w_busy;
  assign w_drop      = bus.ad_done && bus.enable && w_busy;
  assign w_a_sel_inc = (r_a_sel == LAST_CH) ? 3'd0 : r_a_sel + 3'd1;
`ifdef CHK_EN
  assign w_advance   = w_busy && !bus.wr_full;
`endif

  assign bus.wr_en   = w_busy && !bus.wr_full;
  assign bus.wr_data = r_wr_data;
  assign bus.a_sel   = r_a_sel;
  assign bus.busy    = w_busy;
  assign bus.ovf_cnt = r_ovf_cnt;

  // Next word is loaded on the edge that leaves the current state, so wr_data holds while stalled.
  always_comb begin
    w_state_next   = r_state;
    w_wr_data_next = r_wr_data;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (r_a_sel == 3'd0) begin
            w_state_next   = HDR;
            w_wr_data_next = HDR_WORD;
          end else begin
            w_state_next   = WA;
            w_wr_data_next = {1'b0, r_a_sel, bus.dataa};
          end
        end
      end
      HDR: begin
        if (!bus.wr_full) begin
          w_state_next   = WA;
          w_wr_data_next = {1'b0, r_cap_ch, r_dataa};
        end
      end
      WA: begin
        if (!bus.wr_full) begin
          w_state_next   = WB;
          w_wr_data_next = {1'b1, r_cap_ch, r_datab};
        end
      end
      WB: begin
        if (!bus.wr_full) begin
          w_state_next = IDLE;
`ifdef CHK_EN
          if (r_cap_ch == LAST_CH && !r_abort && bus.enable) begin
            w_state_next   = CHK;
            w_wr_data_next = r_chk ^ r_wr_data;
          end
`endif
        end
      end
`ifdef CHK_EN
      CHK: begin
        if (!bus.wr_full) begin
          w_state_next = IDLE;
        end
      end
`endif
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_next;
      r_wr_data <= w_wr_data_next;
    end
  end

  // Dropped conversions still step the address so the sweep stays aligned with the ADC.
  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sel   <= '0;
      r_cap_ch  <= '0;
      r_dataa   <= '0;
      r_datab   <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (!bus.enable) begin
        r_a_sel <= 3'd0;
      end else if (bus.ad_done) begin
        r_a_sel <= w_a_sel_inc;
      end
      if (w_accept) begin
        r_cap_ch <= r_a_sel;
        r_dataa  <= bus.dataa;
        r_datab  <= bus.datab;
      end
      if (w_drop && r_ovf_cnt != 8'hFF) begin
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
    end
  end

`ifdef CHK_EN
  // r_abort remembers an enable drop during the conversion so its checksum is suppressed.
  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_abort <= 1'b0;
      r_chk   <= '0;
    end else begin
      if (w_accept) begin
        r_abort <= 1'b0;
      end else if (!bus.enable && w_busy) begin
        r_abort <= 1'b1;
      end
      if (w_advance) begin
        if (r_state == HDR) begin
          r_chk <= '0;
        end else if (r_state == WA || r_state == WB) begin
          r_chk <= r_chk ^ r_wr_data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ad7266_frame_packer.sv
// tb/tb_ad7266_frame_packer.sv - bench for ad7266_frame_packer (NUM_CH=8 and NUM_CH=1 instances)
// Reference model is a per-instance queue of words still owed downstream.
module tb_ad7266_frame_packer;

  logic SCLK;
  logic rst_n;

  ad7266_frame_packer_if ifa();
  ad7266_frame_packer_if ifb();

  ad7266_frame_packer #(.NUM_CH(8), .HDR_WORD(16'hA55A)) u_dut8 (
    .SCLK  (SCLK),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  ad7266_frame_packer #(.NUM_CH(1), .HDR_WORD(16'hA55A)) u_dut1 (
    .SCLK  (SCLK),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  int n_checks = 0;
  int n_errors = 0;

  int          m_cnt  [2];
  logic [1:0]  m_kind [2][4];
  logic [15:0] m_val  [2][4];
  int          m_asel [2];
  int          m_ovf  [2];
  logic [15:0] m_acc  [2];

  logic [15:0] got0[$];
  logic [15:0] got1[$];
  logic [15:0] expq[$];
  logic        s_wr_en;
  logic [15:0] s_wr_data;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [2:0]  exp_asel;
    logic [15:0] exp_wa;
    logic [15:0] exp_wb;
  } conv_t;
  conv_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_asel[k] = 0;
      m_ovf[k]  = 0;
      m_acc[k]  = '0;
    end
  endtask

  task automatic push(input int k, input logic [1:0] kd, input logic [15:0] v);
    m_kind[k][m_cnt[k]] = kd;
    m_val[k][m_cnt[k]]  = v;
    m_cnt[k]++;
  endtask

  task automatic drive(input logic en, input logic done, input logic full,
                       input logic [11:0] da, input logic [11:0] db);
    ifa.enable = en; ifa.ad_done = done; ifa.wr_full = full; ifa.dataa = da; ifa.datab = db;
    ifb.enable = en; ifb.ad_done = done; ifb.wr_full = full; ifb.dataa = da; ifb.datab = db;
  endtask

  task automatic step(input logic en, input logic done, input logic full,
                      input logic [11:0] da, input logic [11:0] db);
    logic        o_busy [2];
    logic        o_wen  [2];
    logic [15:0] o_wd   [2];
    logic [2:0]  o_asel [2];
    logic [7:0]  o_ovf  [2];
    int          n;
    logic        was_busy;
    logic [2:0]  chb;
    drive(en, done, full, da, db);
    @(negedge SCLK);
    o_busy[0] = ifa.busy; o_wen[0] = ifa.wr_en; o_wd[0] = ifa.wr_data; o_asel[0] = ifa.a_sel; o_ovf[0] = ifa.ovf_cnt;
    o_busy[1] = ifb.busy; o_wen[1] = ifb.wr_en; o_wd[1] = ifb.wr_data; o_asel[1] = ifb.a_sel; o_ovf[1] = ifb.ovf_cnt;
    s_wr_en   = o_wen[0];
    s_wr_data = o_wd[0];
    if (o_wen[0]) got0.push_back(o_wd[0]);
    if (o_wen[1]) got1.push_back(o_wd[1]);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(m_cnt[k] != 0));
      chk($sformatf("wr_en%0d", k), 32'(o_wen[k]), 32'((m_cnt[k] != 0) && !full));
      chk($sformatf("a_sel%0d", k), 32'(o_asel[k]), 32'(m_asel[k]));
      chk($sformatf("ovf_cnt%0d", k), 32'(o_ovf[k]), 32'(m_ovf[k]));
      if (m_cnt[k] != 0)
        chk($sformatf("wr_data%0d", k), 32'(o_wd[k]),
            32'((m_kind[k][0] == 2'd3) ? m_acc[k] : m_val[k][0]));
    end
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 8 : 1;
      was_busy = (m_cnt[k] != 0);
      if (!en && was_busy && m_kind[k][0] != 2'd3 && m_kind[k][m_cnt[k]-1] == 2'd3)
        m_cnt[k]--;
      if (m_cnt[k] != 0 && !full) begin
        if (m_kind[k][0] == 2'd0) m_acc[k] = '0;
        else if (m_kind[k][0] != 2'd3) m_acc[k] = m_acc[k] ^ m_val[k][0];
        for (int j = 0; j < 3; j++) begin
          m_kind[k][j] = m_kind[k][j+1];
          m_val[k][j]  = m_val[k][j+1];
        end
        m_cnt[k]--;
      end
      if (done && en) begin
        if (!was_busy) begin
          chb = 3'(m_asel[k]);
          if (m_asel[k] == 0) push(k, 2'd0, 16'hA55A);
          push(k, 2'd1, {1'b0, chb, da});
          push(k, 2'd2, {1'b1, chb, db});
`ifdef CHK_EN
          if (m_asel[k] == n - 1) push(k, 2'd3, 16'h0000);
`endif
        end else if (m_ovf[k] < 255) begin
          m_ovf[k]++;
        end
      end
      if (!en) m_asel[k] = 0;
      else if (done) m_asel[k] = (m_asel[k] + 1) % n;
    end
    @(posedge SCLK);
    #1;
  endtask

  initial begin
    int wpc;
`ifdef CHK_EN
    wpc = 4;
`else
    wpc = 3;
`endif
    tbl[0] = '{12'h100, 12'h200, 3'd1, 16'h0100, 16'h8200};
    tbl[1] = '{12'h101, 12'h201, 3'd2, 16'h1101, 16'h9201};
    tbl[2] = '{12'h102, 12'h202, 3'd3, 16'h2102, 16'hA202};
    tbl[3] = '{12'h103, 12'h203, 3'd4, 16'h3103, 16'hB203};
    tbl[4] = '{12'h104, 12'h204, 3'd5, 16'h4104, 16'hC204};
    tbl[5] = '{12'h105, 12'h205, 3'd6, 16'h5105, 16'hD205};
    tbl[6] = '{12'h106, 12'h206, 3'd7, 16'h6106, 16'hE206};
    tbl[7] = '{12'h107, 12'h207, 3'd0, 16'h7107, 16'hF207};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
    model_reset();
    repeat (2) @(posedge SCLK);
    #1;
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_wr_en", 32'(ifa.wr_en), 32'd0);
    chk("rst_wr_data", 32'(ifa.wr_data), 32'd0);
    chk("rst_a_sel", 32'(ifa.a_sel), 32'd0);
    chk("rst_ovf", 32'(ifa.ovf_cnt), 32'd0);
    @(negedge SCLK);
    rst_n = 1'b1;
    @(posedge SCLK);
    #1;

    // full sweep, one conversion every 20 cycles
    got0.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, tbl[i].a, tbl[i].b);
      chk("sweep_a_sel", 32'(ifa.a_sel), 32'(tbl[i].exp_asel));
      repeat (19) step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    end
    expq.delete();
    expq.push_back(16'hA55A);
    for (int i = 0; i < 8; i++) begin
      expq.push_back(tbl[i].exp_wa);
      expq.push_back(tbl[i].exp_wb);
    end
`ifdef CHK_EN
    expq.push_back(16'h0000);
`endif
    chk("sweep_len", 32'(got0.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < got0.size(); i++)
      chk($sformatf("sweep_word%0d", i), 32'(got0[i]), 32'(expq[i]));
    chk("sweep_ovf", 32'(ifa.ovf_cnt), 32'd0);

    // conversion arriving one cycle after an accept is dropped
    got0.delete();
    step(1'b1, 1'b1, 1'b0, 12'h0AA, 12'h0BB);
    step(1'b1, 1'b1, 1'b0, 12'h111, 12'h222);
    chk("drop_ovf", 32'(ifa.ovf_cnt), 32'd1);
    chk("drop_a_sel", 32'(ifa.a_sel), 32'd2);
    repeat (10) step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    chk("drop_len", 32'(got0.size()), 32'd3);
    if (got0.size() == 3) begin
      chk("drop_hdr", 32'(got0[0]), 32'h0000A55A);
      chk("drop_wa", 32'(got0[1]), 32'h000000AA);
      chk("drop_wb", 32'(got0[2]), 32'h000080BB);
    end

    // wr_full stall while the WA word is presented
    step(1'b1, 1'b1, 1'b0, 12'h123, 12'h456);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 12'h0, 12'h0);
      chk("stall_wr_en", 32'(s_wr_en), 32'd0);
      chk("stall_hold", 32'(s_wr_data), 32'h00002123);
    end
    step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    chk("stall_wa_en", 32'(s_wr_en), 32'd1);
    chk("stall_wa", 32'(s_wr_data), 32'h00002123);
    step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    chk("stall_wb_en", 32'(s_wr_en), 32'd1);
    chk("stall_wb", 32'(s_wr_data), 32'h0000A456);
    step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    chk("stall_done", 32'(s_wr_en), 32'd0);

    // enable dropped during WA of channel 3
    step(1'b1, 1'b1, 1'b0, 12'h333, 12'h444);
    step(1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
    chk("endrop_wa", 32'(s_wr_data), 32'h00003333);
    chk("endrop_a_sel", 32'(ifa.a_sel), 32'd0);
    step(1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
    chk("endrop_wb", 32'(s_wr_data), 32'h0000B444);
    step(1'b0, 1'b1, 1'b0, 12'h0, 12'h0);
    chk("endrop_idle", 32'(s_wr_en), 32'd0);
    step(1'b1, 1'b1, 1'b0, 12'h555, 12'h666);
    step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    chk("reen_hdr", 32'(s_wr_data), 32'h0000A55A);
    repeat (6) step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           12'($urandom), 12'($urandom));
    repeat (8) step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);

    // overflow saturation with the output blocked
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1, 1'b1, 12'($urandom), 12'($urandom));
      step(1'b1, 1'b0, 1'b1, 12'h0, 12'h0);
    end
    chk("sat_ovf8", 32'(ifa.ovf_cnt), 32'd255);
    chk("sat_ovf1", 32'(ifb.ovf_cnt), 32'd255);
    repeat (10) step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);

    // asynchronous reset while the NUM_CH=1 instance presents its header
    step(1'b1, 1'b1, 1'b0, 12'hABC, 12'hDEF);
    #2;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    #1;
    chk("mid_rst_busy", 32'(ifb.busy), 32'd0);
    chk("mid_rst_wr_en", 32'(ifb.wr_en), 32'd0);
    chk("mid_rst_wr_data", 32'(ifb.wr_data), 32'd0);
    chk("mid_rst_a_sel", 32'(ifb.a_sel), 32'd0);
    chk("mid_rst_ovf", 32'(ifb.ovf_cnt), 32'd0);
    model_reset();
    @(negedge SCLK);
    rst_n = 1'b1;
    @(posedge SCLK);
    #1;
    got1.delete();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 12'($urandom), 12'($urandom));
      repeat (7) step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    end
    chk("one_ch_len", 32'(got1.size()), 32'(3 * wpc));
    if (got1.size() == 3 * wpc) begin
      chk("one_ch_hdr0", 32'(got1[0]), 32'h0000A55A);
      chk("one_ch_hdr1", 32'(got1[wpc]), 32'h0000A55A);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ad7266_frame_packer.md
# ad7266_frame_packer

Channel sequencer and framer between the AD7266 capture logic and the USB transfer buffer. Steps the ADC channel address through a sweep, captures each A/B sample pair on conversion-done, and emits tagged 16-bit words: a header per sweep, two sample words per conversion, and an optional checksum. Runs entirely in the ADC serial-clock domain. Its output write port feeds the cross-domain buffer that the USB sender drains.

## Interface
- NUM_CH, 8, channels per sweep, legal 1..8
- HDR_WORD, 16'hA55A, sweep header word
- SCLK  in  1  ADC serial clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  sweep enable, level
- ad_done  in  1  one-cycle pulse; dataa/datab valid in that cycle
- dataa  in  12  ADC port A sample
- datab  in  12  ADC port B sample
- a_sel  out  3  channel address to ADC (A2..A0)
- wr_full  in  1  downstream cannot accept a word this cycle
- wr_en  out  1  word valid and written this cycle
- wr_data  out  16  output word
- busy  out  1  FSM not IDLE
- ovf_cnt  out  8  dropped conversions, saturating

## Operation
- States: IDLE, HDR, WA, WB, CHK.
- Accepted conversion: ad_done=1 && enable=1 && state==IDLE. Capture dataa, datab, cap_ch=a_sel; a_sel advances to a_sel+1, wrapping NUM_CH-1 -> 0.
- From IDLE on accept: cap_ch==0 -> HDR, else -> WA.
- HDR -> WA -> WB. WB -> CHK if cap_ch==NUM_CH-1 and CHK_EN compiled in, else IDLE. CHK -> IDLE.
- A state advances only in a cycle with wr_full=0; otherwise it holds, and wr_data holds.
- Words: HDR = HDR_WORD; WA = {1'b0, cap_ch, dataa}; WB = {1'b1, cap_ch, datab}; CHK = XOR of all WA/WB words written since the last HDR.
- Dropped conversion: ad_done=1 && enable=1 && state!=IDLE. Samples discarded. ovf_cnt increments and saturates at 255. a_sel still advances so addressing stays aligned. The dropped pair contributes nothing to CHK.
- enable=0: ad_done ignored and not counted. a_sel forced to 0 on the next edge. An in-flight WA/WB finishes, then the FSM goes to IDLE with CHK suppressed. The next accepted conversion starts with HDR.
- The checksum accumulator clears when HDR is written.

## Timing
- Reset: state IDLE, a_sel=0, wr_en=0, wr_data=0, busy=0, ovf_cnt=0, checksum accumulator=0.
- wr_en is combinational: (state in HDR/WA/WB/CHK) && !wr_full. wr_data is registered.
- Accept at edge T: the first word is valid in cycle T+1. Each following word takes one cycle when wr_full stays 0.
- Words per conversion:
  - mid-sweep: 2
  - channel 0: 3
  - last channel with CHK_EN: 3, or 4 if NUM_CH=1
- Busy window, unstalled: 2 to 4 cycles. ad_done in the same cycle the FSM returns to IDLE is accepted.
- NUM_CH=1: every conversion is both first and last: HDR, WA, WB, CHK.
- Reset mid-frame: outputs go to reset values immediately. No partial word is completed.

## Configuration
- CHK_EN defined: CHK state present; the checksum word follows the last channel's WB.
- CHK_EN undefined: no CHK state and no accumulator logic; frames are HDR plus NUM_CH word pairs.

## Test plan
- NUM_CH=8, CHK_EN, wr_full=0, 8 ad_done pulses 20 cycles apart, dataa=0x100+ch, datab=0x200+ch:
  - stream = A55A, 0100, 8200, 1101, 9201 … 7107, F207, then XOR of the 16 sample words.
  - a_sel sequence 1..7, 0.
- ad_done in cycle T+1 after an accept: ovf_cnt=1, no extra words, a_sel advanced by 2 total, CHK excludes the dropped pair.
- wr_full=1 for 5 cycles during WA: wr_en=0, wr_data holds the WA word, WA written on the first cycle wr_full=0, WB follows next cycle.
- enable dropped during WA of channel 3: WA and WB written, no CHK, a_sel=0. After re-enable, first word is A55A.
- 300 ad_done pulses with wr_full held at 1: ovf_cnt saturates at 255 and stays there.
- Reset asserted mid-HDR, CHK_EN undefined, NUM_CH=1: all outputs reset. After release, each conversion yields exactly 3 words: HDR, WA, WB.
